// File: rtl/ctrl.sv
// Pipeline control: fetch PC sequencing, redirect/hold arbitration and sticky status.
// Latency: hold/flush outputs are combinational; pc, state, counters and flags update one edge later.
// Backpressure: hold2ctrl freezes pc and the front pipeline registers; a jump always overrides a hold.
module ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int          HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] jump_addr2ctrl,
  input  logic        jump_en2ctrl,
  input  logic        hold2ctrl,
  output logic [31:0] pc,
  output logic        hold_pc,
  output logic        hold_id_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [1:0]  state,
  output logic [15:0] redirect_cnt,
  output logic        misalign,
  output logic        hold_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    HOLD     = 2'b01,
    REDIRECT = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_t      cur_state;
  state_t      nxt_state;
  logic [7:0]  hold_cnt;
  logic [7:0]  hold_cnt_nxt;
  logic [31:0] pc_nxt;
  logic        hold_acc;
  logic        jump_bad;

  assign state    = cur_state;
  // A jump always wins over a concurrent hold; the hold is re-sampled in REDIRECT.
  assign hold_acc = hold2ctrl && !jump_en2ctrl;
  assign jump_bad = jump_en2ctrl && (jump_addr2ctrl[1:0] != 2'b00);

  // Next-state, next-pc and the combinational hold/flush controls.
  always_comb begin
    nxt_state    = RUN;
    pc_nxt       = pc + 32'd4;
    hold_cnt_nxt = 8'd0;
    hold_pc      = 1'b0;
    hold_id_ex   = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;

    if (jump_en2ctrl) begin
      nxt_state = REDIRECT;
      pc_nxt    = jump_bad ? TRAP_PC : jump_addr2ctrl;
    end else if (hold2ctrl) begin
      nxt_state    = HOLD;
      pc_nxt       = pc;
      hold_cnt_nxt = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
    end

    // Outputs are suppressed entirely during reset so nothing leaks past release.
    if (!rst) begin
      if (jump_en2ctrl) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else begin
        // The word fetched from the old path in the redirect cycle is stale.
        if (cur_state == REDIRECT) flush_if_id = 1'b1;
        if (hold2ctrl) begin
          hold_pc    = 1'b1;
          hold_id_ex = 1'b1;
        end
      end
    end
  end

  // State register, pc and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= RUN;
      pc        <= RESET_PC;
      hold_cnt  <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      pc        <= pc_nxt;
      hold_cnt  <= hold_cnt_nxt;
    end
  end

  // Redirect counter (saturating) and sticky status flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt <= 16'd0;
      misalign     <= 1'b0;
      hold_timeout <= 1'b0;
    end else begin
      if (jump_en2ctrl && (redirect_cnt != 16'hFFFF)) redirect_cnt <= redirect_cnt + 16'd1;
      if (jump_bad) misalign <= 1'b1;
      if (hold_acc && (hold_cnt_nxt == HOLD_MAX_C)) hold_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl.sv
// Directed bench for ctrl: scoreboarded pc/state per cycle plus direct control-output checks.
// Expected pc/state are queued when each cycle's stimulus is driven and compared after the edge.
// Inputs are driven 1 time unit after the rising edge; outputs sampled before the next edge.
module tb_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] jump_addr2ctrl;
  logic        jump_en2ctrl;
  logic        hold2ctrl;
  logic [31:0] pc;
  logic        hold_pc;
  logic        hold_id_ex;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [1:0]  state;
  logic [15:0] redirect_cnt;
  logic        misalign;
  logic        hold_timeout;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   passed;
  int   total;

  ctrl #(
    .RESET_PC(32'h0000_0000),
    .TRAP_PC (32'h0000_0100),
    .HOLD_MAX(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_addr2ctrl(jump_addr2ctrl),
    .jump_en2ctrl  (jump_en2ctrl),
    .hold2ctrl     (hold2ctrl),
    .pc            (pc),
    .hold_pc       (hold_pc),
    .hold_id_ex    (hold_id_ex),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .state         (state),
    .redirect_cnt  (redirect_cnt),
    .misalign      (misalign),
    .hold_timeout  (hold_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) passed = passed + 1;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of stimulus and queue the pc/state expected after the edge.
  task automatic drive(input logic j, input logic [31:0] a, input logic h,
                       input logic [31:0] epc, input logic [1:0] est);
    exp_t e;
    jump_en2ctrl   = j;
    jump_addr2ctrl = a;
    hold2ctrl      = h;
    e.pc = epc;
    e.st = est;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic advance(input string tag);
    exp_t e;
    tick();
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_state"}, 32'(state), 32'(e.st));
    end
  endtask

  task automatic chk_ctl(input string tag, input logic hp, input logic hx,
                         input logic fi, input logic fx);
    chk({tag, "_hold_pc"}, 32'(hold_pc), 32'(hp));
    chk({tag, "_hold_id_ex"}, 32'(hold_id_ex), 32'(hx));
    chk({tag, "_flush_if_id"}, 32'(flush_if_id), 32'(fi));
    chk({tag, "_flush_id_ex"}, 32'(flush_id_ex), 32'(fx));
  endtask

  initial begin
    logic [31:0] epc;
    passed         = 0;
    total          = 0;
    rst            = 1'b1;
    jump_en2ctrl   = 1'b0;
    jump_addr2ctrl = 32'd0;
    hold2ctrl      = 1'b0;
    tick();
    tick();

    // Requests during reset must not reach the control outputs.
    jump_en2ctrl   = 1'b1;
    jump_addr2ctrl = 32'h44;
    hold2ctrl      = 1'b1;
    #1;
    chk_ctl("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_redirect_cnt", 32'(redirect_cnt), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_timeout", 32'(hold_timeout), 32'd0);

    // Free-running fetch: 0, 4, 8, 12.
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd4, 2'd0);
    chk_ctl("run", 1'b0, 1'b0, 1'b0, 1'b0);
    advance("run1");
    drive(1'b0, 32'd0, 1'b0, 32'd8, 2'd0);
    advance("run2");
    drive(1'b0, 32'd0, 1'b0, 32'd12, 2'd0);
    advance("run3");

    // Three-cycle hold at pc 12, then resume.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 1'b1, 32'd12, 2'd1);
      chk_ctl($sformatf("hold3_%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      advance($sformatf("hold3_%0d", i));
    end
    drive(1'b0, 32'd0, 1'b0, 32'd16, 2'd0);
    chk_ctl("hold3_rel", 1'b0, 1'b0, 1'b0, 1'b0);
    advance("hold3_rel");
    chk("hold3_timeout", 32'(hold_timeout), 32'd0);

    // Reset pulse, then redirect from pc 8 to 0x40.
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0);
    advance("rst2");
    rst = 1'b0;
    chk("rst2_redirect_cnt", 32'(redirect_cnt), 32'd0);
    drive(1'b0, 32'd0, 1'b0, 32'd4, 2'd0);
    advance("run_b1");
    drive(1'b0, 32'd0, 1'b0, 32'd8, 2'd0);
    advance("run_b2");
    drive(1'b1, 32'h40, 1'b0, 32'h40, 2'd2);
    chk_ctl("jump40", 1'b0, 1'b0, 1'b1, 1'b1);
    advance("jump40");
    chk("jump40_cnt", 32'(redirect_cnt), 32'd1);
    drive(1'b0, 32'd0, 1'b0, 32'h44, 2'd0);
    chk_ctl("redir40", 1'b0, 1'b0, 1'b1, 1'b0);
    advance("redir40");
    drive(1'b0, 32'd0, 1'b0, 32'h48, 2'd0);
    chk_ctl("after40", 1'b0, 1'b0, 1'b0, 1'b0);
    advance("after40");

    // Misaligned target traps and sets the sticky flag.
    drive(1'b1, 32'h42, 1'b0, 32'h100, 2'd2);
    advance("jump42");
    chk("jump42_misalign", 32'(misalign), 32'd1);
    chk("jump42_cnt", 32'(redirect_cnt), 32'd2);
    epc = 32'h100;
    for (int i = 0; i < 10; i++) begin
      epc = epc + 32'd4;
      drive(1'b0, 32'd0, 1'b0, epc, 2'd0);
      advance($sformatf("post42_%0d", i));
    end
    chk("misalign_sticky", 32'(misalign), 32'd1);

    // Jump and hold together: jump wins, hold re-sampled in REDIRECT.
    drive(1'b1, 32'h80, 1'b1, 32'h80, 2'd2);
    chk_ctl("jh", 1'b0, 1'b0, 1'b1, 1'b1);
    advance("jh");
    chk("jh_cnt", 32'(redirect_cnt), 32'd3);
    drive(1'b0, 32'd0, 1'b1, 32'h80, 2'd1);
    chk("jh_redir_flush_if_id", 32'(flush_if_id), 32'd1);
    chk("jh_redir_flush_id_ex", 32'(flush_id_ex), 32'd0);
    advance("jh_redir");
    drive(1'b0, 32'd0, 1'b0, 32'h84, 2'd0);
    advance("jh_rel");

    // Long hold: timeout from the 16th hold cycle onward.
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 32'd0, 1'b1, 32'h84, 2'd1);
      advance($sformatf("hold20_%0d", i));
      chk($sformatf("hold20_timeout_%0d", i), 32'(hold_timeout), (i >= 16) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of HOLD.
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 32'd0, 2'd0);
    chk_ctl("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    advance("rst_hold");
    chk("rst_hold_misalign", 32'(misalign), 32'd0);
    chk("rst_hold_timeout", 32'(hold_timeout), 32'd0);
    chk("rst_hold_cnt", 32'(redirect_cnt), 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd4, 2'd0);
    chk_ctl("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    advance("post_rst");

    // pc wraps modulo 2^32.
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 2'd2);
    advance("jmp_top");
    drive(1'b0, 32'd0, 1'b0, 32'd0, 2'd0);
    advance("wrap");
    chk("wrap_cnt", 32'(redirect_cnt), 32'd1);

    // Redirect counter saturates at 16'hFFFF.
    jump_en2ctrl   = 1'b1;
    jump_addr2ctrl = 32'h200;
    hold2ctrl      = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_reach", 32'(redirect_cnt), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(redirect_cnt), 32'hFFFF);
    chk("sat_pc", pc, 32'h200);
    jump_en2ctrl = 1'b0;
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
